// File: rtl/game_cpu_ocimem_pkg.sv
// Shared types and jdo field positions for the debug monitor memory controller.
package game_cpu_ocimem_pkg;
    localparam int WORD_W        = 32;
    localparam int JDO_W         = 38;
    localparam int JDO_ADDR_LSB  = 26;
    localparam int JDO_ADDR_W    = 8;
    localparam int JDO_RD_BIT    = 35;
    localparam int JDO_CLR_BIT   = 25;
    localparam int JDO_WDATA_LSB = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_J_RD,
        ST_J_CAP,
        ST_J_WR,
        ST_C_RD,
        ST_C_DONE
    } state_t;

    typedef enum logic [1:0] {
        CMD_LOAD,
        CMD_WRITE,
        CMD_READ
    } cmd_kind_t;

    typedef struct packed {
        cmd_kind_t             kind;
        logic [JDO_ADDR_W-1:0] addr;
        logic                  rd;
        logic                  clr;
        logic [WORD_W-1:0]     wdata;
    } jtag_cmd_t;

    // True when the command touches the RAM (and therefore drops monitor_ready).
    function automatic logic is_mem_op(jtag_cmd_t c);
        return (c.kind != CMD_LOAD) || c.rd;
    endfunction
endpackage

// File: rtl/game_cpu_cpu_debug_ocimem_if.sv
// CPU-side Avalon-MM word port into the debug RAM.
interface game_cpu_cpu_debug_ocimem_if #(parameter int ADDR_W = 8);
    import game_cpu_ocimem_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [WORD_W-1:0] writedata;
    logic [3:0]        byteenable;
    logic [WORD_W-1:0] readdata;
    logic              waitrequest;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, waitrequest
    );
endinterface

// File: rtl/game_cpu_ocimem_ram.sv
// Single-port debug RAM: synchronous read with 1-cycle latency, byte-lane writes.
// Read-before-write: q returns the old word on a write cycle.
module game_cpu_ocimem_ram
    import game_cpu_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        be,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] q
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        q <= mem[addr];
    end
endmodule

// File: rtl/game_cpu_cpu_debug_ocimem.sv
// Debug monitor memory: JTAG load/read/write on a debug RAM plus an optional Avalon CPU port
// (GAME_CPU_OCIMEM_CPU_PORT_EN). JTAG read 2 clk, write 1 clk; JTAG wins, CPU stalled via waitrequest.
// Pulses during a CPU op wait in a 1-deep slot; pulses while JTAG busy or slot full set monitor_error.
module game_cpu_cpu_debug_ocimem
    import game_cpu_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [JDO_W-1:0]            jdo,
    input  logic                        take_action_ocimem_a,
    input  logic                        take_action_ocimem_b,
    input  logic                        take_no_action_ocimem_a,
    game_cpu_cpu_debug_ocimem_if.slave  avalon,
    output logic [WORD_W-1:0]           MonDReg,
    output logic                        monitor_ready,
    output logic                        monitor_error
);
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] mon_areg;
    logic [WORD_W-1:0] wr_dat;

    jtag_cmd_t pulse_cmd, pend_cmd, exec_cmd;
    logic      pulse_vld, pend_vld, exec_vld;
    logic      idle, cpu_busy, pulse_hold, pulse_drop;

    logic              cpu_wr_go, cpu_rd_go;
    logic [ADDR_W-1:0] cpu_addr;
    logic [WORD_W-1:0] cpu_wdat;
    logic [3:0]        cpu_be;

    logic              ram_we, ram_we_gated;
    logic [ADDR_W-1:0] ram_addr;
    logic [3:0]        ram_be;
    logic [WORD_W-1:0] ram_wdata, ram_q;

    logic unused_jdo;
    assign unused_jdo = ^{jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_WDATA_LSB-1:0]};

    always_comb begin
        pulse_vld       = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
        pulse_cmd.kind  = take_action_ocimem_a ? CMD_LOAD :
                          (take_action_ocimem_b ? CMD_WRITE : CMD_READ);
        pulse_cmd.addr  = jdo[JDO_ADDR_LSB +: JDO_ADDR_W];
        pulse_cmd.rd    = jdo[JDO_RD_BIT];
        pulse_cmd.clr   = jdo[JDO_CLR_BIT];
        pulse_cmd.wdata = jdo[JDO_WDATA_LSB +: WORD_W];
    end

    assign idle       = (state == ST_IDLE);
    assign cpu_busy   = (state == ST_C_RD) || (state == ST_C_DONE);
    // A held command is served before any fresh pulse; the fresh one is then lost.
    assign exec_vld   = idle && (pend_vld || pulse_vld);
    assign exec_cmd   = pend_vld ? pend_cmd : pulse_cmd;
    assign pulse_hold = pulse_vld && cpu_busy && !pend_vld;
    assign pulse_drop = pulse_vld && !(idle && !pend_vld) && !pulse_hold;

`ifdef GAME_CPU_OCIMEM_CPU_PORT_EN
    logic              cpu_go;
    logic [WORD_W-1:0] rdata_q;

    assign cpu_go    = idle && !pulse_vld && !pend_vld;
    assign cpu_wr_go = cpu_go && avalon.write;
    assign cpu_rd_go = cpu_go && avalon.read && !avalon.write;
    assign cpu_addr  = avalon.address;
    assign cpu_wdat  = avalon.writedata;
    assign cpu_be    = avalon.byteenable;

    assign avalon.waitrequest = (avalon.read || avalon.write) &&
                                !(cpu_wr_go || ((state == ST_C_RD) && avalon.read));
    assign avalon.readdata    = (state == ST_C_RD) ? ram_q : rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (state == ST_C_RD) begin
            rdata_q <= ram_q;
        end
    end
`else
    logic unused_avalon;
    assign unused_avalon = ^{avalon.address, avalon.read, avalon.write,
                             avalon.writedata, avalon.byteenable};

    assign cpu_wr_go = 1'b0;
    assign cpu_rd_go = 1'b0;
    assign cpu_addr  = '0;
    assign cpu_wdat  = '0;
    assign cpu_be    = '0;

    assign avalon.waitrequest = 1'b0;
    assign avalon.readdata    = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ram_we    = 1'b0;
        ram_addr  = mon_areg;
        ram_be    = 4'hF;
        ram_wdata = wr_dat;
        case (state)
            ST_IDLE: begin
                if (exec_vld && is_mem_op(exec_cmd)) begin
                    state_nxt = (exec_cmd.kind == CMD_WRITE) ? ST_J_WR : ST_J_RD;
                end else if (cpu_rd_go) begin
                    state_nxt = ST_C_RD;
                    ram_addr  = cpu_addr;
                end else if (cpu_wr_go) begin
                    ram_we    = 1'b1;
                    ram_addr  = cpu_addr;
                    ram_be    = cpu_be;
                    ram_wdata = cpu_wdat;
                end
            end
            ST_J_RD:   state_nxt = ST_J_CAP;
            ST_J_CAP:  state_nxt = ST_IDLE;
            ST_J_WR: begin
                ram_we    = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_C_RD:   state_nxt = ST_C_DONE;
            ST_C_DONE: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // A reset landing mid-write must leave the RAM untouched.
    assign ram_we_gated = ram_we && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            mon_areg      <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
            wr_dat        <= '0;
            pend_vld      <= 1'b0;
            pend_cmd      <= '0;
        end else begin
            if (pulse_hold) begin
                pend_vld <= 1'b1;
                pend_cmd <= pulse_cmd;
            end else if (idle) begin
                pend_vld <= 1'b0;
            end

            if (exec_vld) begin
                if (exec_cmd.kind == CMD_LOAD) begin
                    mon_areg <= exec_cmd.addr[ADDR_W-1:0];
                    if (exec_cmd.clr) monitor_error <= 1'b0;
                end
                if (exec_cmd.kind == CMD_WRITE) wr_dat <= exec_cmd.wdata;
            end

            if ((exec_vld && is_mem_op(exec_cmd)) || (pulse_hold && is_mem_op(pulse_cmd)))
                monitor_ready <= 1'b0;

            if (state == ST_J_CAP) begin
                MonDReg       <= ram_q;
                mon_areg      <= mon_areg + 1'b1;
                monitor_ready <= 1'b1;
            end

            if (state == ST_J_WR) begin
                mon_areg      <= mon_areg + 1'b1;
                monitor_ready <= 1'b1;
            end

            if (pulse_drop) monitor_error <= 1'b1;
        end
    end

    game_cpu_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (ram_we_gated),
        .addr  (ram_addr),
        .be    (ram_be),
        .wdata (ram_wdata),
        .q     (ram_q)
    );
endmodule
